// File: rtl/mpc_chan_initiator.sv
// Request-side engine for one mpc channel: registers commands onto the channel,
// tracks outstanding loads in order, and reports completions, fences and errors.

package mpc_pkg;

    typedef enum logic {
        MPC_OP_LOAD  = 1'b0,
        MPC_OP_STORE = 1'b1
    } mpc_op_e;

    typedef struct packed {
        mpc_op_e      op;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } channel_req_t;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FENCE_WAIT = 2'd1,
        ST_ERROR      = 2'd2
    } chan_state_e;

endpackage

module mpc_chan_initiator
    import mpc_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                                clk,
    input  logic                                rst,

    // Handshakes: a transfer happens on an edge where valid && ready; a
    // valid producer holds its payload stable and never drops valid before
    // that transfer.
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_fence,
    input  mpc_op_e                             cmd_op,
    input  logic [31:0]                         cmd_addr,
    input  logic [127:0]                        cmd_wdata,

    output logic                                req_bus_valid,
    input  logic                                req_bus_ready,
    output channel_req_t                        req_bus,

    input  logic                                rsp_bus_valid,
    output logic                                rsp_bus_ready,
    input  logic [127:0]                        rsp_bus_rdata,

    output logic                                done_valid,
    input  logic                                done_ready,
    output logic [31:0]                         done_addr,
    output logic [127:0]                        done_rdata,

    output logic [$clog2(MaxOutstanding):0]     outstanding,
    output logic                                err_timeout,
    output logic                                err_unexpected,
    output logic [15:0]                         stat_loads,
    output logic [15:0]                         stat_stores,
    output chan_state_e                         fsm_state
);

    localparam int unsigned AW = $clog2(MaxOutstanding);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = $clog2(TimeoutCycles + 1);

    localparam logic [CW-1:0] FIFO_DEPTH = CW'(MaxOutstanding);
    localparam logic [WW-1:0] WD_LAST    = WW'(TimeoutCycles - 1);
    localparam logic [WW-1:0] WD_MAX     = WW'(TimeoutCycles);

    chan_state_e   state_q, state_d;

    channel_req_t  req_q;
    logic          req_valid_q;

    logic [31:0]   fifo_mem [MaxOutstanding];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          done_valid_q;
    logic [31:0]   done_addr_q;
    logic [127:0]  done_rdata_q;

    logic [WW-1:0] wd_q;

    logic slot_free;
    logic fifo_full;
    logic fifo_empty;
    logic cmd_fire;
    logic slot_load;
    logic push;
    logic pop;
    logic req_fire;
    logic rsp_unexpected;
    logic wd_run;
    logic wd_expire;

    assign slot_free  = !req_valid_q || req_bus_ready;
    assign fifo_full  = (count_q == FIFO_DEPTH);
    assign fifo_empty = (count_q == '0);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cmd_valid && cmd_fence) begin
                    state_d = ST_FENCE_WAIT;
                end else if (cmd_op == MPC_OP_STORE) begin
                    cmd_ready = slot_free;
                end else begin
                    // No pop-then-push bypass: a full FIFO refuses even if it drains this cycle.
                    cmd_ready = slot_free && !fifo_full;
                end
            end
            ST_FENCE_WAIT: begin
                cmd_ready = !req_valid_q && fifo_empty && !done_valid_q;
                if (cmd_valid && cmd_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                cmd_ready = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (wd_expire) begin
            state_d = ST_ERROR;
        end
        if (rst) begin
            cmd_ready = 1'b0;
        end
    end

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign slot_load = cmd_fire && (state_q == ST_RUN);
    assign push      = slot_load && (cmd_op == MPC_OP_LOAD);

    // ------------------------------------------------------------------
    // Request slot and issue statistics
    // ------------------------------------------------------------------
    assign req_fire = req_valid_q && req_bus_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
        end else if (slot_load) begin
            req_valid_q <= 1'b1;
            req_q.op    <= cmd_op;
            req_q.addr  <= cmd_addr;
            req_q.wdata <= cmd_wdata;
        end else if (req_bus_ready) begin
            req_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
        end else if (req_fire) begin
            if (req_q.op == MPC_OP_LOAD) begin
                stat_loads <= stat_loads + 16'd1;
            end else begin
                stat_stores <= stat_stores + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // In-order load address FIFO
    // ------------------------------------------------------------------
    always_comb begin
        rsp_bus_ready = 1'b0;
        if (rst) begin
            rsp_bus_ready = 1'b0;
        end else if (fifo_empty) begin
            // Nothing is owed: swallow a stray response so the channel cannot wedge.
            rsp_bus_ready = rsp_bus_valid;
        end else begin
            rsp_bus_ready = !done_valid_q || done_ready;
        end
    end

    assign pop            = rsp_bus_valid && rsp_bus_ready && !fifo_empty;
    assign rsp_unexpected = rsp_bus_valid && fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Completion register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            done_valid_q <= 1'b0;
            done_addr_q  <= '0;
            done_rdata_q <= '0;
        end else if (pop) begin
            done_valid_q <= 1'b1;
            done_addr_q  <= fifo_mem[rd_ptr_q];
            done_rdata_q <= rsp_bus_rdata;
        end else if (done_ready) begin
            done_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Response watchdog and sticky error flags
    // ------------------------------------------------------------------
    assign wd_run    = !fifo_empty && !pop;
    assign wd_expire = wd_run && (wd_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (!wd_run) begin
            wd_q <= '0;
        end else if (wd_q != WD_MAX) begin
            wd_q <= wd_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout    <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            if (wd_expire) begin
                err_timeout <= 1'b1;
            end
            if (rsp_unexpected) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    // Valids are masked during reset so no handshake can complete in that cycle.
    assign req_bus_valid = req_valid_q && !rst;
    assign req_bus       = req_q;
    assign done_valid    = done_valid_q && !rst;
    assign done_addr     = done_addr_q;
    assign done_rdata    = done_rdata_q;
    assign outstanding   = count_q;
    assign fsm_state     = state_q;

endmodule
